// File: rtl/mv_avalon_loader_p_pkg.sv
// Shared types and geometry helpers for the matrix-vector Avalon loader.
// Derives elements per word, words per row and total words from the parameters.
package mv_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int calc_epw(input int bus_w, input int elem_w);
        return bus_w / elem_w;
    endfunction

    function automatic int calc_wpr(input int cols, input int epw);
        return (cols + epw - 1) / epw;
    endfunction

    // The extra row of words holds the B vector.
    function automatic int calc_total(input int rows, input int wpr);
        return (rows + 1) * wpr;
    endfunction

endpackage

// File: rtl/mv_avalon_loader_p_if.sv
// Avalon-MM read-only bus between the loader (master) and memory (slave).
interface mv_avalon_loader_p_if #(
    parameter int BUS_W = 64
);
    logic [31:0]      address;
    logic             read;
    logic [BUS_W-1:0] readdata;
    logic             readdatavalid;
    logic             waitrequest;

    modport master (
        output address, read,
        input  readdata, readdatavalid, waitrequest
    );

    modport slave (
        input  address, read,
        output readdata, readdatavalid, waitrequest
    );
endinterface

// File: rtl/mvl_resp_fifo.sv
// Synchronous show-ahead FIFO holding read responses until they are unpacked.
module mvl_resp_fifo #(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = 64,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            // NOTE: the buffer is small and must read back as zero after reset, so it is cleared like any other register.
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= inc_ptr(wr_ptr);
            end
            if (do_pop) rd_ptr <= inc_ptr(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/mv_avalon_loader_p.sv
// Pipelined Avalon-MM loader: fetches matrix A and vector B, unpacks one element per cycle into FIFOs.
// Optional perf_stall/perf_wait counters are built when MVL_PERF_CNT_EN is defined.
module mv_avalon_loader_p
    import mv_loader_pkg::*;
#(
    parameter int ROWS     = 8,
    parameter int COLS     = 8,
    parameter int ELEM_W   = 8,
    parameter int BUS_W    = 64,
    parameter int MAX_PEND = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [31:0]                  cfg_base,
    mv_avalon_loader_p_if.master         avm,
    output logic [ROWS-1:0]              a_wren,
    output logic [ROWS-1:0][ELEM_W-1:0]  a_data,
    output logic                         b_wren,
    output logic [ELEM_W-1:0]            b_data,
    input  logic [ROWS-1:0]              a_full,
    input  logic                         b_full,
    output logic                         busy,
    output logic                         done,
    output logic                         err_rdv,
`ifdef MVL_PERF_CNT_EN
    output logic [31:0]                  perf_stall,
    output logic [31:0]                  perf_wait,
`endif
    output logic [1:0]                   dbg_state
);
    localparam int EPW      = calc_epw(BUS_W, ELEM_W);
    localparam int WPR      = calc_wpr(COLS, EPW);
    localparam int TOTAL    = calc_total(ROWS, WPR);
    localparam int LAST_CNT = COLS - (WPR - 1) * EPW;
    localparam int ISS_W    = $clog2(TOTAL + 1);
    localparam int PEND_W   = $clog2(MAX_PEND + 1);
    localparam int ROW_W    = $clog2(ROWS + 1);
    localparam int CW_W     = (WPR > 1) ? $clog2(WPR) : 1;
    localparam int EI_W     = (EPW > 1) ? $clog2(EPW) : 1;
    localparam logic [EI_W-1:0] FULL_LAST = EI_W'(EPW - 1);
    localparam logic [EI_W-1:0] ROW_LAST  = EI_W'(LAST_CNT - 1);

    if (BUS_W % ELEM_W != 0) begin : g_bad_elem_w
        $error("mv_avalon_loader_p: BUS_W must be a multiple of ELEM_W");
    end
    if (MAX_PEND < 1) begin : g_bad_pend
        $error("mv_avalon_loader_p: MAX_PEND must be at least 1");
    end

    state_t             state_q, state_d;
    logic [31:0]        addr_q;
    logic [ISS_W-1:0]   issued_q;
    logic [PEND_W-1:0]  in_flight_q;
    logic [ROW_W-1:0]   row_q;
    logic [CW_W-1:0]    cw_q;
    logic [EI_W-1:0]    ei_q;
    logic [EI_W-1:0]    last_idx;
    logic [BUS_W-1:0]   fifo_rdata;
    logic [PEND_W-1:0]  fifo_count;
    logic [PEND_W:0]    pend_sum;
    logic [ELEM_W-1:0]  elem;
    logic               fifo_empty, fifo_full;
    logic               start_ok, accept, rdv_ok;
    logic               tgt_full, wr_fire, pop, final_pop;

    assign start_ok  = start && (state_q != RUN);
    assign accept    = avm.read && !avm.waitrequest;
    assign rdv_ok    = avm.readdatavalid && (in_flight_q != '0);
    assign pend_sum  = {1'b0, in_flight_q} + {1'b0, fifo_count};
    assign avm.address = addr_q;

    mvl_resp_fifo #(
        .DEPTH (MAX_PEND),
        .WIDTH (BUS_W)
    ) u_resp_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (rdv_ok),
        .wdata (avm.readdata),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    // Target selection: rows 0..ROWS-1 feed A FIFOs, row index ROWS is the B vector.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        tgt_full = b_full;
        for (int r = 0; r < ROWS; r++) begin
            if (row_q == ROW_W'(r)) tgt_full = a_full[r];
        end
        last_idx = (cw_q == CW_W'(WPR - 1)) ? ROW_LAST : FULL_LAST;
    end

    assign wr_fire   = (state_q == RUN) && !fifo_empty && !tgt_full;
    assign pop       = wr_fire && (ei_q == last_idx);
    assign final_pop = pop && (row_q == ROW_W'(ROWS)) && (cw_q == CW_W'(WPR - 1));
    assign elem      = fifo_rdata[ei_q * ELEM_W +: ELEM_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: sequential state always uses non-blocking assignments so every register sees pre-edge values.
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (final_pop) state_d = DONE;
            DONE:    if (start) state_d = RUN;
            default: state_d = IDLE;
        endcase
    end

    // Outstanding plus buffered reads never exceed MAX_PEND, so every response has a slot.
    always_comb begin
        busy      = (state_q == RUN);
        done      = (state_q == DONE);
        dbg_state = state_q;
        avm.read  = (state_q == RUN) && (issued_q < ISS_W'(TOTAL))
                    && (pend_sum < (PEND_W + 1)'(MAX_PEND));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q      <= '0;
            issued_q    <= '0;
            in_flight_q <= '0;
            row_q       <= '0;
            cw_q        <= '0;
            ei_q        <= '0;
            err_rdv     <= 1'b0;
        end else begin
            if (avm.readdatavalid && (in_flight_q == '0)) err_rdv <= 1'b1;
            case ({accept, rdv_ok})
                2'b10:   in_flight_q <= in_flight_q + 1'b1;
                2'b01:   in_flight_q <= in_flight_q - 1'b1;
                default: ;
            endcase
            if (start_ok) begin
                addr_q   <= cfg_base;
                issued_q <= '0;
                row_q    <= '0;
                cw_q     <= '0;
                ei_q     <= '0;
            end else begin
                if (accept) begin
                    addr_q   <= addr_q + 32'd1;
                    issued_q <= issued_q + 1'b1;
                end
                if (pop) begin
                    ei_q <= '0;
                    if (cw_q == CW_W'(WPR - 1)) begin
                        cw_q  <= '0;
                        row_q <= row_q + 1'b1;
                    end else begin
                        cw_q <= cw_q + 1'b1;
                    end
                end else if (wr_fire) begin
                    ei_q <= ei_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_wren <= '0;
            a_data <= '0;
            b_wren <= 1'b0;
            b_data <= '0;
        end else begin
            a_wren <= '0;
            b_wren <= 1'b0;
            if (wr_fire) begin
                if (row_q == ROW_W'(ROWS)) begin
                    b_wren <= 1'b1;
                    b_data <= elem;
                end else begin
                    a_wren <= ROWS'(1) << row_q;
                    a_data <= {ROWS{elem}};
                end
            end
        end
    end

`ifdef MVL_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_stall <= '0;
            perf_wait  <= '0;
        end else if (start_ok) begin
            perf_stall <= '0;
            perf_wait  <= '0;
        end else begin
            if ((state_q == RUN) && !fifo_empty && tgt_full && (perf_stall != '1))
                perf_stall <= perf_stall + 32'd1;
            if (avm.read && avm.waitrequest && (perf_wait != '1))
                perf_wait <= perf_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mv_avalon_loader_p.sv
// Directed bench: default 8x8 loader with memory model, plus a COLS=10 instance for multi-word rows.
module tb_mv_avalon_loader_p;
    localparam int ROWS  = 8;
    localparam int COLS  = 8;
    localparam int COLS2 = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] elem_val(input logic [31:0] addr, input int k);
        return 8'((addr * 32'd8) + 32'(k) + 32'd1) ^ 8'(addr >> 3);
    endfunction

    function automatic logic [63:0] word_val(input logic [31:0] addr);
        logic [63:0] w;
        for (int k = 0; k < 8; k++) w[k*8 +: 8] = elem_val(addr, k);
        return w;
    endfunction

    // ---------------- DUT 1: defaults ----------------
    mv_avalon_loader_p_if #(.BUS_W(64)) bus1 ();
    logic                 start1 = 1'b0;
    logic [31:0]          base1 = '0;
    logic [ROWS-1:0]      a_wren1;
    logic [ROWS-1:0][7:0] a_data1;
    logic                 b_wren1;
    logic [7:0]           b_data1;
    logic [ROWS-1:0]      a_full1 = '0;
    logic                 busy1, done1, err1;
    logic [1:0]           dbg1;
    logic                 wait1 = 1'b0;
    logic                 inject_rdv = 1'b0;
`ifdef MVL_PERF_CNT_EN
    logic [31:0] ps1, pw1, ps2, pw2;
`endif

    mv_avalon_loader_p u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start1),
        .cfg_base  (base1),
        .avm       (bus1),
        .a_wren    (a_wren1),
        .a_data    (a_data1),
        .b_wren    (b_wren1),
        .b_data    (b_data1),
        .a_full    (a_full1),
        .b_full    (1'b0),
        .busy      (busy1),
        .done      (done1),
        .err_rdv   (err1),
`ifdef MVL_PERF_CNT_EN
        .perf_stall(ps1),
        .perf_wait (pw1),
`endif
        .dbg_state (dbg1)
    );

    logic        r1v_a = 1'b0, r1v_b = 1'b0, rdv1 = 1'b0;
    logic [31:0] r1a_a = '0, r1a_b = '0;
    logic [63:0] rdata1 = '0;
    always @(posedge clk) begin
        r1v_a  <= bus1.read && !bus1.waitrequest;
        r1a_a  <= bus1.address;
        r1v_b  <= r1v_a;
        r1a_b  <= r1a_a;
        rdv1   <= r1v_b;
        rdata1 <= word_val(r1a_b);
    end
    assign bus1.readdatavalid = rdv1 | inject_rdv;
    assign bus1.readdata      = rdata1;
    assign bus1.waitrequest   = wait1;

    int          cyc = 0;
    int          acc1 = 0, wait_obs1 = 0, tot_wr1 = 0, cnt_b1 = 0;
    int          cnt_a1 [ROWS];
    logic [7:0]  got_a1 [ROWS][COLS];
    logic [7:0]  got_b1 [COLS];
    logic [31:0] cur_base1 = '0, prev_addr1 = '0;
    logic        prev_stall1 = 1'b0;
    logic [ROWS-1:0] full_seen1 = '0;
    int          first_rdv1 = -1, first_wr1 = -1, row0_first = -1, row0_last = -1;

    always @(negedge clk) begin
        cyc++;
        if (prev_stall1) begin
            check("stall_hold_read", bus1.read, 1'b1);
            check("stall_hold_addr", bus1.address, prev_addr1);
        end
        prev_stall1 = bus1.read && bus1.waitrequest;
        prev_addr1  = bus1.address;
        if (prev_stall1) wait_obs1++;
        if (bus1.read && !bus1.waitrequest) begin
            check("req_addr", bus1.address, cur_base1 + 32'(acc1));
            acc1++;
        end
        if (busy1 && bus1.readdatavalid && first_rdv1 < 0) first_rdv1 = cyc;
        if (a_wren1 != '0) check("a_wren_onehot", 32'($countones(a_wren1)), 64'd1);
        for (int r = 0; r < ROWS; r++) begin
            if (a_wren1[r]) begin
                if (first_wr1 < 0) first_wr1 = cyc;
                check("a_wr_while_full", full_seen1[r], 1'b0);
                if (cnt_a1[r] < COLS) begin
                    check("a_data", a_data1[r], elem_val(cur_base1 + 32'(r), cnt_a1[r]));
                    got_a1[r][cnt_a1[r]] = a_data1[r];
                    if (r == 0 && cnt_a1[r] == 0) row0_first = cyc;
                    if (r == 0 && cnt_a1[r] == COLS - 1) row0_last = cyc;
                end else begin
                    check("a_extra_write", a_wren1[r], 1'b0);
                end
                cnt_a1[r]++;
                tot_wr1++;
            end
        end
        if (b_wren1) begin
            if (cnt_b1 < COLS) begin
                check("b_data", b_data1, elem_val(cur_base1 + 32'(ROWS), cnt_b1));
                got_b1[cnt_b1] = b_data1;
            end else begin
                check("b_extra_write", b_wren1, 1'b0);
            end
            cnt_b1++;
            tot_wr1++;
        end
        full_seen1 = a_full1;
    end

    // ---------------- DUT 2: COLS=10, two words per row ----------------
    mv_avalon_loader_p_if #(.BUS_W(64)) bus2 ();
    logic                 start2 = 1'b0;
    logic [31:0]          base2 = '0;
    logic [ROWS-1:0]      a_wren2;
    logic [ROWS-1:0][7:0] a_data2;
    logic                 b_wren2;
    logic [7:0]           b_data2;
    logic                 busy2, done2, err2;
    logic [1:0]           dbg2;

    mv_avalon_loader_p #(.COLS(COLS2)) u_dut2 (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start2),
        .cfg_base  (base2),
        .avm       (bus2),
        .a_wren    (a_wren2),
        .a_data    (a_data2),
        .b_wren    (b_wren2),
        .b_data    (b_data2),
        .a_full    ('0),
        .b_full    (1'b0),
        .busy      (busy2),
        .done      (done2),
        .err_rdv   (err2),
`ifdef MVL_PERF_CNT_EN
        .perf_stall(ps2),
        .perf_wait (pw2),
`endif
        .dbg_state (dbg2)
    );

    logic        r2v_a = 1'b0, r2v_b = 1'b0, rdv2 = 1'b0;
    logic [31:0] r2a_a = '0, r2a_b = '0;
    logic [63:0] rdata2 = '0;
    always @(posedge clk) begin
        r2v_a  <= bus2.read;
        r2a_a  <= bus2.address;
        r2v_b  <= r2v_a;
        r2a_b  <= r2a_a;
        rdv2   <= r2v_b;
        rdata2 <= word_val(r2a_b);
    end
    assign bus2.readdatavalid = rdv2;
    assign bus2.readdata      = rdata2;
    assign bus2.waitrequest   = 1'b0;

    int          acc2 = 0, cnt_b2 = 0, tot_wr2 = 0;
    int          cnt_a2 [ROWS];
    logic [31:0] cur_base2 = '0;

    always @(negedge clk) begin
        if (bus2.read) begin
            check("req_addr2", bus2.address, cur_base2 + 32'(acc2));
            if (acc2 == 16) check("b_base_addr2", bus2.address, cur_base2 + 32'd16);
            acc2++;
        end
        for (int r = 0; r < ROWS; r++) begin
            if (a_wren2[r]) begin
                if (cnt_a2[r] < COLS2)
                    check("a_data2", a_data2[r],
                          elem_val(cur_base2 + 32'(r * 2 + cnt_a2[r] / 8), cnt_a2[r] % 8));
                else
                    check("a_pad_pushed2", a_wren2[r], 1'b0);
                cnt_a2[r]++;
                tot_wr2++;
            end
        end
        if (b_wren2) begin
            if (cnt_b2 < COLS2)
                check("b_data2", b_data2, elem_val(cur_base2 + 32'(16 + cnt_b2 / 8), cnt_b2 % 8));
            else
                check("b_pad_pushed2", b_wren2, 1'b0);
            cnt_b2++;
            tot_wr2++;
        end
    end

    // ---------------- Stimulus helpers ----------------
    task automatic do_start1(input logic [31:0] b);
        cur_base1  = b;
        acc1       = 0;
        wait_obs1  = 0;
        tot_wr1    = 0;
        cnt_b1     = 0;
        first_rdv1 = -1;
        first_wr1  = -1;
        row0_first = -1;
        row0_last  = -1;
        for (int r = 0; r < ROWS; r++) cnt_a1[r] = 0;
        base1  = b;
        start1 = 1'b1;
        @(posedge clk); #2;
        start1 = 1'b0;
        base1  = 32'hDEAD_0000;
    endtask

    task automatic wait_done1(input string tag);
        int n = 0;
        while (!done1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(tag, done1, 1'b1);
        @(posedge clk); #2;
    endtask

    task automatic check_counts1(input string tag);
        for (int r = 0; r < ROWS; r++) check({tag, "_row_cnt"}, 32'(cnt_a1[r]), 64'(COLS));
        check({tag, "_b_cnt"}, 32'(cnt_b1), 64'(COLS));
        check({tag, "_reads"}, 32'(acc1), 64'd9);
        check({tag, "_busy"}, busy1, 1'b0);
        check({tag, "_state"}, dbg1, 2'd2);
    endtask

    initial begin
        int n;
        logic [31:0] c_got, c_exp;
        for (int r = 0; r < ROWS; r++) begin
            cnt_a1[r] = 0;
            cnt_a2[r] = 0;
        end
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;

        @(negedge clk);
        check("rst_read", bus1.read, 1'b0);
        check("rst_addr", bus1.address, 32'd0);
        check("rst_a_wren", a_wren1, '0);
        check("rst_a_data", a_data1, '0);
        check("rst_b_wren", b_wren1, 1'b0);
        check("rst_b_data", b_data1, '0);
        check("rst_busy", busy1, 1'b0);
        check("rst_done", done1, 1'b0);
        check("rst_err", err1, 1'b0);
        check("rst_state", dbg1, 2'd0);

        // Stray readdatavalid while idle.
        @(posedge clk); #2 inject_rdv = 1'b1;
        @(posedge clk); #2 inject_rdv = 1'b0;
        @(negedge clk);
        check("idle_rdv_err", err1, 1'b1);
        check("idle_rdv_writes", 32'(tot_wr1), 64'd0);
        check("idle_rdv_busy", busy1, 1'b0);
        @(posedge clk); #2;

        // Load 1: no stalls, both instances; a start while running is ignored.
        cur_base2 = 32'h200;
        acc2      = 0;
        base2     = 32'h200;
        start2    = 1'b1;
        do_start1(32'h0);
        start2    = 1'b0;
        repeat (4) @(posedge clk);
        #2 start1 = 1'b1; base1 = 32'h999;
        @(posedge clk); #2 start1 = 1'b0;
        wait_done1("load1_done");
        check_counts1("load1");
        check("load1_total_writes", 32'(tot_wr1), 64'd72);
        check("load1_row0_burst", 32'(row0_last - row0_first), 64'd7);
        check("load1_latency", 32'(first_wr1 - first_rdv1), 64'd2);
        n = 0;
        while (!done2 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #2;
        check("cols10_done", done2, 1'b1);
        check("cols10_reads", 32'(acc2), 64'd18);
        for (int r = 0; r < ROWS; r++) check("cols10_row_cnt", 32'(cnt_a2[r]), 64'(COLS2));
        check("cols10_b_cnt", 32'(cnt_b2), 64'(COLS2));
        check("cols10_total", 32'(tot_wr2), 64'd90);

        // Load 2: row 3 FIFO full for 20 cycles.
        do_start1(32'h40);
        n = 0;
        while (cnt_a1[2] < 4 && n < 500) begin
            @(posedge clk); #2;
            n++;
        end
        check("full_trigger", cnt_a1[2] >= 4, 1'b1);
        a_full1[3] = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        check("full_row3_held", 32'(cnt_a1[3]), 64'd0);
        check("full_read_stalled", bus1.read, 1'b0);
        check("full_reads_issued", 32'(acc1), 64'd7);
        a_full1[3] = 1'b0;
        wait_done1("load2_done");
        check_counts1("load2");

        // Load 3: waitrequest held for 5 cycles on the third request.
        do_start1(32'h80);
        n = 0;
        while (acc1 < 2 && n < 500) begin
            @(posedge clk); #2;
            n++;
        end
        check("wait_trigger", 32'(acc1), 64'd2);
        wait1 = 1'b1;
        repeat (5) @(posedge clk);
        #2 wait1 = 1'b0;
        wait_done1("load3_done");
        check("wait_cycles", 32'(wait_obs1), 64'd5);
        check_counts1("load3");

        // Load 4: reset mid-run, then a clean reload.
        do_start1(32'hC0);
        repeat (6) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_busy", busy1, 1'b0);
        check("midrst_read", bus1.read, 1'b0);
        check("midrst_addr", bus1.address, 32'd0);
        check("midrst_a_wren", a_wren1, '0);
        check("midrst_state", dbg1, 2'd0);
        check("midrst_err", err1, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_err", err1, 1'b0);
        check("post_rst_done", done1, 1'b0);
        @(posedge clk); #2;
        do_start1(32'h100);
        wait_done1("reload_done");
        check_counts1("reload");
        for (int r = 0; r < ROWS; r++) begin
            c_got = '0;
            c_exp = '0;
            for (int c = 0; c < COLS; c++) begin
                c_got += 32'(got_a1[r][c]) * 32'(got_b1[c]);
                c_exp += 32'(elem_val(32'h100 + 32'(r), c)) * 32'(elem_val(32'h108, c));
            end
            check("reload_c_row", c_got, c_exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
